// File: rtl/cpu_pkg.sv
// Shared CPU constants and index/data typedefs, reused by decode, write-back and the register file.
package cpu_pkg;

  localparam int unsigned DATA_WIDTH = 64;
  localparam int unsigned ADDR_WIDTH = 5;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned ZERO_REG   = 31;

  typedef logic [ADDR_WIDTH-1:0] reg_idx_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

  // Write-back request as seen by the register file.
  typedef struct packed {
    logic     valid;
    reg_idx_t idx;
    data_t    data;
  } wb_req_t;

  function automatic logic is_zero_reg(input reg_idx_t idx);
    return idx == reg_idx_t'(ZERO_REG);
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard: tracks in-flight producers and flags RAW/WAW stalls.
module reg_scoreboard
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_reg,
  input  logic                  retire_valid,
  input  logic [ADDR_WIDTH-1:0] retire_reg,
  input  logic [ADDR_WIDTH-1:0] read_reg1,
  input  logic [ADDR_WIDTH-1:0] read_reg2,
  output logic                  stall_c
);

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_nxt;
  logic                hit1;
  logic                hit2;
  logic                waw;
  logic                issue_ok;

  // A register retiring this cycle is no longer a hazard: its value is on the bypass.
  always_comb begin
    hit1     = 1'b0;
    hit2     = 1'b0;
    waw      = 1'b0;
    issue_ok = 1'b0;
    stall_c  = 1'b0;

    hit1 = !is_zero_reg(read_reg1) && pending[read_reg1]
           && !(retire_valid && (retire_reg == read_reg1));
    hit2 = !is_zero_reg(read_reg2) && pending[read_reg2]
           && !(retire_valid && (retire_reg == read_reg2));
    waw  = issue_valid && !is_zero_reg(issue_reg) && pending[issue_reg]
           && !(retire_valid && (retire_reg == issue_reg));

    stall_c  = hit1 || hit2 || waw;
    issue_ok = issue_valid && !stall_c && !is_zero_reg(issue_reg);
  end

  // Set after clear so a new producer supersedes the one retiring on the same index.
  always_comb begin
    pending_nxt = pending;
    if (retire_valid) begin
      pending_nxt[retire_reg] = 1'b0;
    end
    if (issue_ok) begin
      pending_nxt[issue_reg] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

endmodule

// File: rtl/reg_file_wb.sv
// Architectural register file (32 x 64) fed by write-back, with bypassed combinational
// read ports and a pending-write scoreboard driving decode Stall.
module reg_file_wb
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] Reg2Write,
  input  logic [DATA_WIDTH-1:0] Data2Write,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] ReadReg1,
  input  logic [ADDR_WIDTH-1:0] ReadReg2,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2,
  input  logic                  IssueValid,
  input  logic [ADDR_WIDTH-1:0] IssueReg,
  output logic                  Stall
);

  wb_req_t wb;
  data_t   regs [NUM_REGS];
  logic    sb_stall_c;

  assign wb = {RegWrite, Reg2Write, Data2Write};

  // Storage; the zero register is never written so it stays 0 from reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wb.valid && !is_zero_reg(wb.idx)) begin
      regs[wb.idx] <= wb.data;
    end
  end

  // Read ports: zero register, then same-cycle bypass, then stored value.
  always_comb begin
    ReadData1 = '0;
    ReadData2 = '0;
    if (!reset) begin
      if (!is_zero_reg(ReadReg1)) begin
        ReadData1 = (wb.valid && (wb.idx == ReadReg1)) ? wb.data : regs[ReadReg1];
      end
      if (!is_zero_reg(ReadReg2)) begin
        ReadData2 = (wb.valid && (wb.idx == ReadReg2)) ? wb.data : regs[ReadReg2];
      end
    end
  end

  reg_scoreboard u_scoreboard (
    .clk          (clk),
    .reset        (reset),
    .issue_valid  (IssueValid),
    .issue_reg    (IssueReg),
    .retire_valid (wb.valid),
    .retire_reg   (wb.idx),
    .read_reg1    (ReadReg1),
    .read_reg2    (ReadReg2),
    .stall_c      (sb_stall_c)
  );

  assign Stall = !reset && sb_stall_c;

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed self-checking bench for reg_file_wb.
module tb_reg_file_wb;

  logic        clk;
  logic        reset;
  logic [4:0]  Reg2Write;
  logic [63:0] Data2Write;
  logic        RegWrite;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic [63:0] ReadData1;
  logic [63:0] ReadData2;
  logic        IssueValid;
  logic [4:0]  IssueReg;
  logic        Stall;

  int checks;
  int errors;

  reg_file_wb dut (
    .clk        (clk),
    .reset      (reset),
    .Reg2Write  (Reg2Write),
    .Data2Write (Data2Write),
    .RegWrite   (RegWrite),
    .ReadReg1   (ReadReg1),
    .ReadReg2   (ReadReg2),
    .ReadData1  (ReadData1),
    .ReadData2  (ReadData2),
    .IssueValid (IssueValid),
    .IssueReg   (IssueReg),
    .Stall      (Stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Step to just after the next rising edge; inputs are then changed for the coming cycle.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RegWrite   = 1'b0;
    Reg2Write  = 5'd0;
    Data2Write = 64'd0;
    IssueValid = 1'b0;
    IssueReg   = 5'd0;
    ReadReg1   = 5'd0;
    ReadReg2   = 5'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    cyc();
    RegWrite = 1'b1; Reg2Write = 5'd4; Data2Write = 64'hAAAA; ReadReg1 = 5'd4;
    #1;
    checks++;
    if (ReadData1 !== 64'd0) begin
      errors++; $display("FAIL reset_bypass_gated got %h want 0", ReadData1);
    end
    cyc();
    idle();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ReadReg1 = 5'(i);
      ReadReg2 = 5'(31 - i);
      #1;
      checks++;
      if (ReadData1 !== 64'd0 || ReadData2 !== 64'd0 || Stall !== 1'b0) begin
        errors++;
        $display("FAIL reset_read idx %0d got %h %h stall %b want 0 0 0", i, ReadData1, ReadData2, Stall);
      end
    end
  endtask

  task automatic test_zero_reg();
    cyc();
    idle();
    RegWrite = 1'b1; Reg2Write = 5'd31; Data2Write = 64'hDEAD; ReadReg1 = 5'd31;
    #1;
    checks++;
    if (ReadData1 !== 64'd0) begin
      errors++; $display("FAIL zero_reg_bypass got %h want 0", ReadData1);
    end
    cyc();
    idle();
    ReadReg1 = 5'd31;
    #1;
    checks++;
    if (ReadData1 !== 64'd0) begin
      errors++; $display("FAIL zero_reg_stored got %h want 0", ReadData1);
    end
  endtask

  task automatic test_bypass();
    cyc();
    idle();
    RegWrite = 1'b1; Reg2Write = 5'd5; Data2Write = 64'h1122334455667788;
    ReadReg1 = 5'd5; ReadReg2 = 5'd6;
    #1;
    checks++;
    if (ReadData1 !== 64'h1122334455667788 || ReadData2 !== 64'd0) begin
      errors++; $display("FAIL bypass got %h %h want 1122334455667788 0", ReadData1, ReadData2);
    end
    cyc();
    idle();
    ReadReg1 = 5'd5; ReadReg2 = 5'd5;
    #1;
    checks++;
    if (ReadData1 !== 64'h1122334455667788 || ReadData2 !== 64'h1122334455667788) begin
      errors++; $display("FAIL bypass_readback got %h %h want 1122334455667788 x2", ReadData1, ReadData2);
    end
  endtask

  task automatic test_raw();
    cyc();
    idle();
    IssueValid = 1'b1; IssueReg = 5'd7;
    #1;
    checks++;
    if (Stall !== 1'b0) begin
      errors++; $display("FAIL raw_issue_accept stall %b want 0", Stall);
    end
    cyc();
    idle();
    ReadReg2 = 5'd7;
    #1;
    checks++;
    if (Stall !== 1'b1) begin
      errors++; $display("FAIL raw_stall stall %b want 1", Stall);
    end
    // Issue of reg 10 while stalled must be dropped.
    IssueValid = 1'b1; IssueReg = 5'd10;
    cyc();
    idle();
    ReadReg2 = 5'd7;
    RegWrite = 1'b1; Reg2Write = 5'd7; Data2Write = 64'h42;
    #1;
    checks++;
    if (Stall !== 1'b0 || ReadData2 !== 64'h42) begin
      errors++; $display("FAIL raw_retire stall %b data %h want 0 42", Stall, ReadData2);
    end
    cyc();
    idle();
    ReadReg1 = 5'd10; ReadReg2 = 5'd7;
    #1;
    checks++;
    if (Stall !== 1'b0 || ReadData2 !== 64'h42) begin
      errors++; $display("FAIL raw_after stall %b data %h want 0 42 (reg10 not pending)", Stall, ReadData2);
    end
  endtask

  task automatic test_set_wins();
    cyc();
    idle();
    IssueValid = 1'b1; IssueReg = 5'd9;
    cyc();
    idle();
    RegWrite = 1'b1; Reg2Write = 5'd9; Data2Write = 64'h99;
    IssueValid = 1'b1; IssueReg = 5'd9;
    #1;
    checks++;
    if (Stall !== 1'b0) begin
      errors++; $display("FAIL set_wins_no_stall stall %b want 0", Stall);
    end
    cyc();
    idle();
    ReadReg1 = 5'd9;
    #1;
    checks++;
    if (Stall !== 1'b1 || ReadData1 !== 64'h99) begin
      errors++; $display("FAIL set_wins_pending stall %b data %h want 1 99", Stall, ReadData1);
    end
    RegWrite = 1'b1; Reg2Write = 5'd9; Data2Write = 64'h100;
    cyc();
    idle();
    ReadReg1 = 5'd9;
    #1;
    checks++;
    if (Stall !== 1'b0 || ReadData1 !== 64'h100) begin
      errors++; $display("FAIL set_wins_cleared stall %b data %h want 0 100", Stall, ReadData1);
    end
  endtask

  task automatic test_waw_reset();
    cyc();
    idle();
    IssueValid = 1'b1; IssueReg = 5'd3;
    cyc();
    idle();
    IssueValid = 1'b1; IssueReg = 5'd3;
    #1;
    checks++;
    if (Stall !== 1'b1) begin
      errors++; $display("FAIL waw_stall stall %b want 1", Stall);
    end
    cyc();
    idle();
    ReadReg1 = 5'd3;
    #1;
    checks++;
    if (Stall !== 1'b1) begin
      errors++; $display("FAIL waw_still_pending stall %b want 1", Stall);
    end
    ReadReg2 = 5'd5;
    RegWrite = 1'b1; Reg2Write = 5'd8; Data2Write = 64'h77;
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (Stall !== 1'b0 || ReadData1 !== 64'd0 || ReadData2 !== 64'd0) begin
      errors++; $display("FAIL reset_mid stall %b data %h %h want 0 0 0", Stall, ReadData1, ReadData2);
    end
    cyc();
    reset = 1'b0;
    idle();
    ReadReg1 = 5'd3; ReadReg2 = 5'd8;
    #1;
    checks++;
    if (Stall !== 1'b0 || ReadData2 !== 64'd0) begin
      errors++; $display("FAIL reset_after stall %b data %h want 0 0", Stall, ReadData2);
    end
  endtask

  task automatic test_dual_port();
    cyc();
    idle();
    IssueValid = 1'b1; IssueReg = 5'd12;
    cyc();
    idle();
    ReadReg1 = 5'd12; ReadReg2 = 5'd12;
    #1;
    checks++;
    if (Stall !== 1'b1) begin
      errors++; $display("FAIL dual_pending stall %b want 1", Stall);
    end
    ReadReg1 = 5'd31; ReadReg2 = 5'd31;
    IssueValid = 1'b1; IssueReg = 5'd31;
    #1;
    checks++;
    if (Stall !== 1'b0 || ReadData1 !== 64'd0 || ReadData2 !== 64'd0) begin
      errors++; $display("FAIL dual_zero stall %b data %h %h want 0 0 0", Stall, ReadData1, ReadData2);
    end
    cyc();
    idle();
    ReadReg1 = 5'd31; ReadReg2 = 5'd31;
    IssueValid = 1'b1; IssueReg = 5'd31;
    #1;
    checks++;
    if (Stall !== 1'b0) begin
      errors++; $display("FAIL zero_never_pending stall %b want 0", Stall);
    end
  endtask

  task automatic test_nonpending_write();
    cyc();
    idle();
    RegWrite = 1'b1; Reg2Write = 5'd20; Data2Write = 64'hCAFEF00D12345678;
    cyc();
    idle();
    ReadReg1 = 5'd20; ReadReg2 = 5'd12;
    #1;
    checks++;
    if (ReadData1 !== 64'hCAFEF00D12345678 || Stall !== 1'b1) begin
      errors++; $display("FAIL nonpending_write data %h stall %b want cafef00d12345678 1", ReadData1, Stall);
    end
    ReadReg2 = 5'd0;
    #1;
    checks++;
    if (Stall !== 1'b0) begin
      errors++; $display("FAIL nonpending_no_stall stall %b want 0", Stall);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_zero_reg();
    test_bypass();
    test_raw();
    test_set_wins();
    test_waw_reset();
    test_dual_port();
    test_nonpending_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
